// File: rtl/chaos_sbox_gen_if.sv
// Handshake bundle between the S-box generator and its requester / table writer.
interface chaos_sbox_gen_if;
    logic        start;
    logic [15:0] seed;
    logic [7:0]  data_out;
    logic        enable_write;
    logic        busy;
    logic        done;

    // Requester / table-writer side
    modport master (
        output start,
        output seed,
        input  data_out,
        input  enable_write,
        input  busy,
        input  done
    );

    // Generator side
    modport slave (
        input  start,
        input  seed,
        output data_out,
        output enable_write,
        output busy,
        output done
    );
endinterface

// File: rtl/chaos_sbox_gen.sv
// Chaotic (logistic-map) S-box generator: emits a 256-byte permutation, one
// strobed byte per accepted candidate, with a lowest-unused fallback after
// MAX_TRIES consecutive collisions.
module chaos_sbox_gen #(
    parameter int unsigned MAX_TRIES = 64,
    parameter logic [15:0] ZERO_SUB  = 16'h9E37
) (
    input  logic            clk,
    input  logic            rst,
    chaos_sbox_gen_if.slave bus
);
    localparam int unsigned XW = 16;
    localparam int unsigned PW = 33;
    localparam int unsigned BW = 8;
    localparam int unsigned NV = 256;
    localparam int unsigned CW = 9;
    localparam int unsigned RW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [NV-1:0]   used_q, used_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   rej_q, rej_d;
    logic [BW-1:0]   data_q, data_d;
    logic            we_q, we_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [PW-1:0]   p_c;
    logic [XW-1:0]   x_sat_c;
    logic [XW-1:0]   x_next_c;
    logic [BW-1:0]   cand_c;
    logic [BW-1:0]   low_c;
    logic [BW-1:0]   emit_val_c;
    logic            emit_c;

    // One logistic-map step x' = 4x(1-x) in Q0.16, saturated and zero-protected
    always_comb begin
        p_c = PW'(x_q) * (PW'(17'h1_0000) - PW'(x_q));
        if (p_c[32:30] != 3'b000) begin
            x_sat_c = 16'hFFFF;
        end else begin
            x_sat_c = p_c[29:14];
        end
        x_next_c = (x_sat_c == '0) ? ZERO_SUB : x_sat_c;
        cand_c   = x_next_c[15:8] ^ x_next_c[7:0];
    end

    // Lowest-index value not yet emitted (fallback byte)
    always_comb begin
        low_c = '0;
        for (int i = NV - 1; i >= 0; i--) begin
            if (!used_q[i]) begin
                low_c = BW'(i);
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        used_d     = used_q;
        cnt_d      = cnt_q;
        rej_d      = rej_q;
        data_d     = data_q;
        we_d       = 1'b0;
        emit_c     = 1'b0;
        emit_val_c = cand_c;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    x_d     = (bus.seed == '0) ? ZERO_SUB : bus.seed;
                    used_d  = '0;
                    cnt_d   = '0;
                    rej_d   = '0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                x_d = x_next_c;
                if (!used_q[cand_c]) begin
                    emit_c     = 1'b1;
                    emit_val_c = cand_c;
                end else if (rej_q == RW'(MAX_TRIES - 1)) begin
                    emit_c     = 1'b1;
                    emit_val_c = low_c;
                end else begin
                    rej_d = rej_q + 1'b1;
                end
                if (emit_c) begin
                    data_d             = emit_val_c;
                    we_d               = 1'b1;
                    used_d[emit_val_c] = 1'b1;
                    cnt_d              = cnt_q + 1'b1;
                    rej_d              = '0;
                    if (cnt_q == CW'(NV - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // done rises one cycle after the final strobe and drops right after a restart
        busy_d = (state_d == S_ITER);
        done_d = (state_q == S_DONE) && (state_d == S_DONE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            used_q  <= '0;
            cnt_q   <= '0;
            rej_q   <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            used_q  <= used_d;
            cnt_q   <= cnt_d;
            rej_q   <= rej_d;
            data_q  <= data_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.data_out     = data_q;
    assign bus.enable_write = we_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_chaos_sbox_gen.sv
// Scoreboard bench for chaos_sbox_gen: expected bytes are queued at stimulus
// time; per-instance monitors pop and compare on every write strobe.
module tb_chaos_sbox_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    chaos_sbox_gen_if bus0();
    chaos_sbox_gen_if bus1();

    chaos_sbox_gen dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    chaos_sbox_gen #(.MAX_TRIES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    logic [7:0] got0[$];
    logic [7:0] got1[$];
    int         strobe_cyc0[$];
    logic [7:0] ref1[256];
    logic [7:0] e0, e1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: logistic map with collision rejection and fallback
    task automatic push_model(input logic [15:0] seed, input int mt, input int n, input bit inst);
        bit used[256];
        int unsigned x;
        longint unsigned p;
        int c, rej, emitted, lo;
        foreach (used[i]) used[i] = 1'b0;
        x = (seed == 16'h0) ? 32'h9E37 : 32'(seed);
        rej = 0;
        emitted = 0;
        while (emitted < n) begin
            p = longint'(x) * longint'(65536 - x);
            if (p >= 64'h4000_0000) x = 65535;
            else x = 32'(p >> 14);
            if (x == 0) x = 32'h9E37;
            c = int'(((x >> 8) ^ x) & 32'hFF);
            if (used[c] && rej < mt - 1) begin
                rej++;
            end else begin
                if (used[c]) begin
                    lo = 0;
                    while (used[lo]) lo++;
                    c = lo;
                end
                used[c] = 1'b1;
                rej = 0;
                emitted++;
                if (inst) exp_q1.push_back(8'(c));
                else exp_q0.push_back(8'(c));
            end
        end
    endtask

    // Monitors: pop expected byte on each strobe
    always @(negedge clk) begin
        if (bus0.enable_write === 1'b1) begin
            got0.push_back(bus0.data_out);
            strobe_cyc0.push_back(cyc);
            if (exp_q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb0_extra: got strobe data_out=%h, expected no strobe (cycle %0d)", bus0.data_out, cyc);
            end else begin
                e0 = exp_q0.pop_front();
                check("sb0_byte", 32'(bus0.data_out), 32'(e0));
            end
        end
    end

    always @(negedge clk) begin
        if (bus1.enable_write === 1'b1) begin
            got1.push_back(bus1.data_out);
            if (exp_q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb1_extra: got strobe data_out=%h, expected no strobe (cycle %0d)", bus1.data_out, cyc);
            end else begin
                e1 = exp_q1.pop_front();
                check("sb1_byte", 32'(bus1.data_out), 32'(e1));
            end
        end
    end

    task automatic start_run(input bit inst, input logic [15:0] s);
        @(negedge clk);
        if (inst) begin bus1.seed = s; bus1.start = 1'b1; end
        else begin bus0.seed = s; bus0.start = 1'b1; end
        start_cyc = cyc;
        @(negedge clk);
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    task automatic wait_strobes(input bit inst, input int target, input string name);
        int n = 0;
        while (((inst ? got1.size() : got0.size()) < target) && n < 20000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, 32'(inst ? got1.size() : got0.size()), 32'(target));
    endtask

    task automatic check_done(input bit inst, input string name);
        @(negedge clk);
        check({name, "_done"}, 32'(inst ? bus1.done : bus0.done), 32'd1);
        check({name, "_busy"}, 32'(inst ? bus1.busy : bus0.busy), 32'd0);
        check({name, "_we"}, 32'(inst ? bus1.enable_write : bus0.enable_write), 32'd0);
        check({name, "_drained"}, 32'(inst ? exp_q1.size() : exp_q0.size()), 32'd0);
    endtask

    task automatic check_perm(input bit inst, input int base, input string name);
        bit seen[256];
        int dup = 0;
        int v;
        foreach (seen[i]) seen[i] = 1'b0;
        if ((inst ? got1.size() : got0.size()) < base + 256) begin
            dup = 999;
        end else begin
            for (int i = 0; i < 256; i++) begin
                v = int'(inst ? got1[base + i] : got0[base + i]);
                if (seen[v]) dup++;
                seen[v] = 1'b1;
            end
        end
        check(name, 32'(dup), 32'd0);
    endtask

    initial begin
        int b1, b2, b3, b4, b6, diffs;
        bus0.start = 1'b0; bus0.seed = 16'h0;
        bus1.start = 1'b0; bus1.seed = 16'h0;

        // Reset state
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_we", 32'(bus0.enable_write), 32'd0);
        check("rst_data", 32'(bus0.data_out), 32'd0);
        check("rst_busy", 32'(bus0.busy), 32'd0);
        check("rst_done", 32'(bus0.done), 32'd0);
        rst = 1'b1;

        // Seed 1234 with an ignored mid-run start pulse and seed change
        b1 = got0.size();
        push_model(16'h1234, 64, 256, 1'b0);
        start_run(1'b0, 16'h1234);
        wait_strobes(1'b0, b1 + 50, "r1_reach50");
        bus0.seed = 16'hFFFF; bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        wait_strobes(1'b0, b1 + 256, "r1_count");
        check("r1_latency", 32'(strobe_cyc0[b1] - start_cyc), 32'd2);
        check("r1_byte0", 32'(got0[b1]), 32'hE1);
        check("r1_byte1", 32'(got0[b1 + 1]), 32'hC8);
        check_perm(1'b0, b1, "r1_perm");
        check_done(1'b0, "r1");
        for (int i = 0; i < 256; i++) ref1[i] = got0[b1 + i];

        // Seed 8000 saturates; start held high while in DONE
        #1;
        b2 = got0.size();
        push_model(16'h8000, 64, 256, 1'b0);
        bus0.seed = 16'h8000; bus0.start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        check("r2_done_drop", 32'(bus0.done), 32'd0);
        check("r2_busy_rise", 32'(bus0.busy), 32'd1);
        repeat (2) @(negedge clk);
        bus0.start = 1'b0;
        wait_strobes(1'b0, b2 + 256, "r2_count");
        check("r2_latency", 32'(strobe_cyc0[b2] - start_cyc), 32'd2);
        check("r2_byte0", 32'(got0[b2]), 32'h00);
        check_perm(1'b0, b2, "r2_perm");
        check_done(1'b0, "r2");

        // Zero seed must match the ZERO_SUB seed byte for byte
        b3 = got0.size();
        push_model(16'h0000, 64, 256, 1'b0);
        start_run(1'b0, 16'h0000);
        wait_strobes(1'b0, b3 + 256, "r3_count");
        check_done(1'b0, "r3");
        b4 = got0.size();
        push_model(16'h9E37, 64, 256, 1'b0);
        start_run(1'b0, 16'h9E37);
        wait_strobes(1'b0, b4 + 256, "r4_count");
        check_done(1'b0, "r4");
        diffs = 0;
        for (int i = 0; i < 256; i++) if (got0[b3 + i] !== got0[b4 + i]) diffs++;
        check("zero_vs_sub_diffs", 32'(diffs), 32'd0);

        // Reset right after the 100th strobe
        push_model(16'h1234, 64, 100, 1'b0);
        start_run(1'b0, 16'h1234);
        wait_strobes(1'b0, b4 + 256 + 100, "r5_reach100");
        rst = 1'b0;
        @(negedge clk);
        check("r5_rst_we", 32'(bus0.enable_write), 32'd0);
        check("r5_rst_busy", 32'(bus0.busy), 32'd0);
        check("r5_rst_done", 32'(bus0.done), 32'd0);
        check("r5_rst_data", 32'(bus0.data_out), 32'd0);
        rst = 1'b1;

        // Restart after reset reproduces the full seed-1234 stream
        b6 = got0.size();
        push_model(16'h1234, 64, 256, 1'b0);
        start_run(1'b0, 16'h1234);
        wait_strobes(1'b0, b6 + 256, "r6_count");
        check_done(1'b0, "r6");
        diffs = 0;
        for (int i = 0; i < 256; i++) if (got0[b6 + i] !== ref1[i]) diffs++;
        check("r6_vs_r1_diffs", 32'(diffs), 32'd0);

        // MAX_TRIES=1: every collision falls back to the lowest unused value
        push_model(16'h1234, 1, 256, 1'b1);
        start_run(1'b1, 16'h1234);
        wait_strobes(1'b1, 256, "m1_count");
        check("m1_byte0", 32'(got1[0]), 32'hE1);
        check("m1_byte1", 32'(got1[1]), 32'hC8);
        check_perm(1'b1, 0, "m1_perm");
        check_done(1'b1, "m1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/chaos_sbox_gen.md
CHAOS_SBOX_GEN -- requirements
Module: chaos_sbox_gen

Interface
REQ-001 Parameter: MAX_TRIES, default 64, consecutive rejected candidates before forced fallback emission.
REQ-002 Parameter: ZERO_SUB, default 16'h9E37, substitute for any all-zero map state.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request to generate a new table; sampled in IDLE and DONE only.
REQ-006 seed  input  16  initial map state, Q0.16; sampled on the accepted start cycle.
REQ-007 data_out  output  8  S-box byte for the downstream table writer; valid while enable_write=1.
REQ-008 enable_write  output  1  one-cycle write strobe per byte; no backpressure, downstream always accepts.
REQ-009 busy  output  1  high in ITER.
REQ-010 done  output  1  level, high in DONE.

Function
REQ-011 States SHALL be IDLE, ITER and DONE.
REQ-012 IDLE/DONE with start=1 SHALL: load x from seed (ZERO_SUB if seed=0); clear 256-bit used bitmap, 9-bit emit count and reject count; go to ITER.
REQ-013 ITER SHALL perform one map iteration per cycle: p = x*(65536-x), 33-bit unsigned; x' = p[29:14] (equivalent to 4x(1-x)); saturate to 16'hFFFF if p[32:30]!=0; replace x'=0 with ZERO_SUB; register x<=x'.
REQ-014 Candidate byte SHALL be c = x'[15:8] XOR x'[7:0].
REQ-015 If used[c]=0: next cycle data_out=c, enable_write=1; set used[c]; count+1; reject count cleared.
REQ-016 If used[c]=1 and reject count < MAX_TRIES-1: no strobe; reject count +1.
REQ-017 If used[c]=1 and reject count = MAX_TRIES-1: emit lowest-index unused value (priority encode over bitmap) as in REQ-015; reject count cleared.
REQ-018 Exactly 256 strobes per run, data_out values forming a permutation of 0..255, no duplicates.
REQ-019 The cycle the 256th strobe is registered, state SHALL go to DONE; done=1 and busy=0 from the cycle after that strobe.
REQ-020 Earliest first strobe SHALL be 2 cycles after the cycle start is sampled high in IDLE.
REQ-021 start during ITER SHALL be ignored; seed changes during ITER SHALL have no effect.
REQ-022 start in DONE SHALL restart per REQ-012; done drops the next cycle.
REQ-023 Output is a pure function of seed, MAX_TRIES and ZERO_SUB; identical inputs give identical streams.
REQ-024 enable_write SHALL be 0 in every cycle other than an emission cycle.

Reset
REQ-025 rst=0 at a rising edge SHALL force IDLE, enable_write=0, data_out=8'h00, busy=0, done=0, x=16'h0000, bitmap/count/reject count cleared.
REQ-026 Reset mid-run SHALL abort; no strobe in the cycle after the reset edge; next start restarts from scratch.

Verification
REQ-027 seed=16'h1234, start 1 cycle -> exactly 256 strobes, values a permutation of 0..255, done=1 the cycle after the last strobe, busy=0.
REQ-028 seed=16'h8000 -> first x'=16'hFFFF (saturated), first data_out=8'h00, two cycles after start.
REQ-029 seed=16'h0000 vs seed=16'h9E37 -> byte-identical 256-entry streams.
REQ-030 MAX_TRIES=1, any seed -> every rejection emits lowest unused value; still 256 strobes, permutation holds.
REQ-031 rst=0 after the 100th strobe -> enable_write=0, busy=0, done=0 next cycle; restart with same seed reproduces the full stream from the first byte.
REQ-032 start pulsed mid-run, and start held high in DONE -> mid-run pulse ignored (stream unchanged); held start in DONE begins a new run with done low next cycle.
